char_text_buffer: RTL and testbench

CHAR_TEXT_BUFFER -- requirements
Module: char_text_buffer

---
 rtl/char_text_buffer.sv | 129 ++++++++++++
 tb/tb_char_text_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/char_text_buffer.sv
// 16x16 character text buffer: 256x7 text RAM with a registered glyph read path
// and a command port (put/setcur/clear) driven by game logic.
module char_text_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_yx,
  input  logic [3:0]  char_line,
  output logic [6:0]  char_code,
  output logic [10:0] font_addr,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic [7:0]  cursor,
  output logic        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [1:0] OP_PUT = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] clr_cnt;
  logic [6:0] ram [256];

  logic       we;
  logic [7:0] wa;
  logic [6:0] wd;

  logic accept;
  logic op_put;
  logic op_set;
  logic op_clr;
  logic is_nl;
  logic is_print;

  assign accept   = cmd_valid & cmd_ready;
  assign op_put   = accept & (cmd_op == OP_PUT);
  assign op_set   = accept & (cmd_op == OP_SET);
  assign op_clr   = accept & (cmd_op == OP_CLR);
  assign is_nl    = cmd_data == 8'h0A;
  assign is_print = (cmd_data >= 8'h20) && (cmd_data <= 8'h7E);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (op_clr) state_nxt = CLEAR;
      CLEAR: if (clr_cnt == 8'hFF) state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // Writes are gated by rst so a reset mid-clear leaves the rest of RAM alone
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    we        = 1'b0;
    wa        = cursor;
    wd        = 7'h20;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        we        = op_put & ~is_nl;
        wd        = is_print ? cmd_data[6:0] : 7'h3F;
      end
      CLEAR: begin
        busy = 1'b1;
        we   = rst;
        wa   = clr_cnt;
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) ram[wa] <= wd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char_code <= '0;
      font_addr <= '0;
    end else begin
      char_code <= ram[char_yx];
      font_addr <= {ram[char_yx], char_line};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 8'd1;
    end else begin
      clr_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cursor <= '0;
    end else begin
      unique case (1'b1)
        op_put: begin
          if (is_nl) cursor <= {cursor[7:4] + 4'd1, 4'd0};
          else       cursor <= cursor + 8'd1;
        end
        op_set:  cursor <= cmd_data;
        op_clr:  cursor <= '0;
        default: cursor <= cursor;
      endcase
    end
  end

endmodule

// File: tb/tb_char_text_buffer.sv
// Directed bench for char_text_buffer: clear timing, put/setcur/newline,
// read-before-write, held command during clear, reset abort mid-clear.
module tb_char_text_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  char_yx;
  logic [3:0]  char_line;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic [7:0]  cursor;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  char_text_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .char_yx   (char_yx),
    .char_line (char_line),
    .char_code (char_code),
    .font_addr (font_addr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cursor    (cursor),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    n = 0;
    while (!cmd_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("send_tmo", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b11;
  endtask

  task automatic rd(input logic [7:0] a, output logic [6:0] v);
    char_yx = a;
    @(negedge clk);
    v = char_code;
  endtask

  task automatic chk_all_blank(input string tag);
    logic [6:0] v;
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      rd(8'(i), v);
      if (v !== 7'h20) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    logic [6:0] v;
    int n;
    rst       = 1'b0;
    char_yx   = 8'h00;
    char_line = 4'h0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b11;
    cmd_data  = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_code", char_code, 0);
    chk("rst_font", font_addr, 0);
    chk("rst_cur", cursor, 0);
    chk("rst_rdy", cmd_ready, 0);
    chk("rst_busy", busy, 1);

    rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 400);
    chk("clr_len", n, 256);
    chk("clr_rdy", cmd_ready, 1);
    chk_all_blank("clr_all");

    send(2'b01, 8'h3E);
    send(2'b00, 8'h41);
    send(2'b00, 8'h42);
    chk("put_cur", cursor, 8'h40);
    rd(8'h3E, v);
    chk("cell_3e", v, 7'h41);
    char_line = 4'd5;
    rd(8'h3F, v);
    chk("cell_3f", v, 7'h42);
    chk("font_adr", font_addr, 11'h425);
    char_line = 4'd0;

    send(2'b01, 8'hFF);
    send(2'b00, 8'h5A);
    chk("wrap_cur", cursor, 8'h00);
    rd(8'hFF, v);
    chk("cell_ff", v, 7'h5A);

    send(2'b01, 8'hF7);
    send(2'b00, 8'h0A);
    chk("nl_wrap", cursor, 8'h00);
    rd(8'hF7, v);
    chk("nl_nowr", v, 7'h20);
    send(2'b01, 8'h23);
    send(2'b00, 8'h0A);
    chk("nl_cur", cursor, 8'h30);

    send(2'b01, 8'h10);
    send(2'b00, 8'h85);
    rd(8'h10, v);
    chk("bad_chr", v, 7'h3F);
    chk("bad_cur", cursor, 8'h11);
    send(2'b11, 8'h77);
    chk("nop_cur", cursor, 8'h11);

    send(2'b01, 8'h10);
    char_yx   = 8'h10;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 8'h41;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b11;
    chk("rbw_old", char_code, 7'h3F);
    @(negedge clk);
    chk("rbw_new", char_code, 7'h41);

    send(2'b10, 8'h00);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 8'h55;
    chk("hold_busy", busy, 1);
    chk("hold_rdy", cmd_ready, 0);
    chk("hold_cur0", cursor, 0);
    n = 0;
    while (!cmd_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("hold_len", n, 256);
    chk("hold_cur", cursor, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b11;
    chk("held_cur", cursor, 1);
    rd(8'h00, v);
    chk("held_put", v, 7'h55);
    rd(8'h10, v);
    chk("clr_10", v, 7'h20);

    send(2'b01, 8'h63);
    send(2'b00, 8'h41);
    send(2'b00, 8'h42);
    send(2'b00, 8'h43);
    send(2'b01, 8'hC8);
    send(2'b00, 8'h44);
    send(2'b10, 8'h00);
    repeat (100) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ab_busy", busy, 1);
    chk("ab_rdy", cmd_ready, 0);
    chk("ab_code", char_code, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    char_yx = 8'h64;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("ab_old64", char_code, 7'h42);
        char_yx = 8'h63;
      end
      if (n == 2) begin
        chk("ab_clr63", char_code, 7'h20);
        char_yx = 8'hC8;
      end
      if (n == 3) chk("ab_oldc8", char_code, 7'h44);
    end while (busy && n < 400);
    chk("ab_len", n, 256);
    chk("ab_rdy1", cmd_ready, 1);
    chk_all_blank("ab_all");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
